// File: rtl/cfg_seq_pkg.sv
// Shared state type, default field layout and cfg-word packing for the sequencer
// and the downstream decoder.
package cfg_pkg;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} cfg_state_e;

    localparam int unsigned CfgAW = 32;
    localparam int unsigned CfgLW = 16;
    localparam int unsigned CfgCW = 16;
    localparam int unsigned CfgB  = 128;

    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned LEN_LSB  = CfgAW;
    localparam int unsigned IDX_LSB  = CfgAW + CfgLW;

    // Wide enough for any supported B; callers zero-extend fields and truncate the result.
    localparam int unsigned PackW = 256;

    function automatic logic [PackW-1:0] cfg_pack(input logic [PackW-1:0] addr,
                                                  input logic [PackW-1:0] len,
                                                  input logic [PackW-1:0] idx,
                                                  input int unsigned      len_lsb,
                                                  input int unsigned      idx_lsb);
        return addr | (len << len_lsb) | (idx << idx_lsb);
    endfunction

endpackage

// File: rtl/cfg_seq_if.sv
// Cfg word stream towards the config-propagation chain, with per-word completion ack.
interface cfg_seq_if #(
    parameter int unsigned B = cfg_pkg::CfgB
) ();
    logic [B-1:0] m_cfg_data;
    logic         m_cfg_valid;
    logic         m_cfg_ready;
    logic         ack;

    modport master (output m_cfg_data, m_cfg_valid, input m_cfg_ready, ack);
    modport slave  (input m_cfg_data, m_cfg_valid, output m_cfg_ready, ack);
endinterface

// File: rtl/cfg_seq_out_cnt.sv
// Count of issued-but-unacknowledged words, with issue-limit compare and underflow detect.
module cfg_out_cnt #(
    parameter  int unsigned MaxOut = 4,
    localparam int unsigned CntW   = $clog2(MaxOut + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic [CntW-1:0] cnt_next_o,
    output logic            below_max_o,
    output logic            underflow_o
);
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d       = cnt_q;
        underflow_o = 1'b0;
        unique case ({inc_i, dec_i})
            2'b10: cnt_d = cnt_q + CntW'(1);
            2'b01: begin
                if (cnt_q == '0) underflow_o = 1'b1;
                else             cnt_d       = cnt_q - CntW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o       = cnt_q;
    assign cnt_next_o  = cnt_d;
    assign below_max_o = (cnt_q < CntW'(MaxOut));

endmodule

// File: rtl/cfg_seq.sv
// Issues a programmed run of cfg words with a strided address, throttled by
// outstanding acks, and pulses done once every word has completed.
module cfg_seq
    import cfg_pkg::*;
#(
    parameter int unsigned B       = 128,
    parameter int unsigned AW      = 32,
    parameter int unsigned LW      = 16,
    parameter int unsigned CW      = 16,
    parameter int unsigned MAX_OUT = 4,
    localparam int unsigned CntW   = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [AW-1:0]     stride,
    input  logic [CW-1:0]     n_cfg,
    input  logic [LW-1:0]     cfg_len,
    cfg_seq_if.master         cfg_bus,
    output logic              busy,
    output logic              done,
    output logic [31:0]       cycle_cnt,
    output logic              err_ack
);
    cfg_state_e      state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d, stride_q, stride_d;
    logic [CW-1:0]   n_q, n_d, idx_q, idx_d;
    logic [LW-1:0]   len_q, len_d;
    logic [31:0]     cycle_cnt_q, cycle_cnt_d;
    logic            err_ack_q, err_ack_d;
    logic            hs, below_max, underflow;
    logic [CntW-1:0] out_cnt, out_cnt_next;

    cfg_out_cnt #(.MaxOut(MAX_OUT)) u_out_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (hs),
        .dec_i       (cfg_bus.ack),
        .cnt_o       (out_cnt),
        .cnt_next_o  (out_cnt_next),
        .below_max_o (below_max),
        .underflow_o (underflow)
    );

    // Valid only falls via a handshake: acks can only lower the count, never raise it.
    assign cfg_bus.m_cfg_valid = (state_q == StIssue) && below_max;
    assign hs                  = cfg_bus.m_cfg_valid && cfg_bus.m_cfg_ready;
    assign cfg_bus.m_cfg_data  = B'(cfg_pack(PackW'(addr_q), PackW'(len_q), PackW'(idx_q),
                                             AW, AW + LW));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        n_d         = n_q;
        idx_d       = idx_q;
        len_d       = len_q;
        cycle_cnt_d = cycle_cnt_q;
        err_ack_d   = err_ack_q | underflow;

        if ((state_q == StIssue || state_q == StDrain) && cycle_cnt_q != '1) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cycle_cnt_d = '0;
                    err_ack_d   = underflow;
                    if (n_cfg != '0) begin
                        addr_d   = base_addr;
                        stride_d = stride;
                        n_d      = n_cfg;
                        len_d    = cfg_len;
                        idx_d    = '0;
                        state_d  = StIssue;
                    end else begin
                        state_d  = StDone;
                    end
                end
            end
            StIssue: begin
                if (hs) begin
                    addr_d = addr_q + stride_q;
                    idx_d  = idx_q + CW'(1);
                    if (idx_q == n_q - CW'(1)) state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_cnt_next == '0) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            stride_q    <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            cycle_cnt_q <= '0;
            err_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            cycle_cnt_q <= cycle_cnt_d;
            err_ack_q   <= err_ack_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign cycle_cnt = cycle_cnt_q;
    assign err_ack   = err_ack_q;

endmodule

// File: tb/tb_cfg_seq.sv
// Randomized bench for cfg_seq against a word-list / counting reference model.
module tb_cfg_seq;

    localparam int MaxOut = 4;
    localparam int Budget = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] stride = '0;
    logic [15:0] n_cfg = '0;
    logic [15:0] cfg_len = '0;
    logic        busy, done, err_ack;
    logic [31:0] cycle_cnt;

    int n_checks = 0;
    int n_pass = 0;

    cfg_seq_if #(.B(128)) bus ();

    cfg_seq #(
        .B       (128),
        .AW      (32),
        .LW      (16),
        .CW      (16),
        .MAX_OUT (MaxOut)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .n_cfg     (n_cfg),
        .cfg_len   (cfg_len),
        .cfg_bus   (bus),
        .busy      (busy),
        .done      (done),
        .cycle_cnt (cycle_cnt),
        .err_ack   (err_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Word i of a run: address base + i*stride (mod 2^32), then len, then index, rest zero.
    function automatic logic [127:0] exp_word(input logic [31:0] b, input logic [31:0] s,
                                              input logic [15:0] l, input int i);
        logic [31:0] a;
        a = b + s * 32'(i);
        return {64'h0, 16'(i), l, a};
    endfunction

    task automatic run_cfg(input logic [31:0] b, input logic [31:0] s, input logic [15:0] n,
                           input logic [15:0] l, input int ready_pct, input int ack_pct,
                           input int ack_delay);
        int  issued, acked, run_cycles;
        bit  seen_done, exp_valid, exp_done;
        @(negedge clk);
        base_addr = b;
        stride    = s;
        n_cfg     = n;
        cfg_len   = l;
        start     = 1'b1;
        bus.ack   = 1'b0;
        bus.m_cfg_ready = ($urandom_range(0, 99) < ready_pct);
        #1;
        check("idle_valid", 128'(bus.m_cfg_valid), 128'(0));
        issued = 0;
        acked = 0;
        run_cycles = 0;
        seen_done = 0;
        for (int cyc = 0; cyc < Budget && !seen_done; cyc++) begin
            @(negedge clk);
            // Inputs and start outside IDLE must be ignored.
            start     = ($urandom_range(0, 3) == 0);
            base_addr = $urandom;
            stride    = $urandom;
            n_cfg     = 16'($urandom);
            cfg_len   = 16'($urandom);
            bus.m_cfg_ready = ($urandom_range(0, 99) < ready_pct);
            bus.ack = (cyc >= ack_delay) && (issued - acked > 0) &&
                      ($urandom_range(0, 99) < ack_pct);
            #1;
            exp_done  = (issued == int'(n)) && (acked == int'(n));
            exp_valid = (issued < int'(n)) && (issued - acked < MaxOut);
            check("valid", 128'(bus.m_cfg_valid), 128'(exp_valid));
            check("busy", 128'(busy), 128'(1));
            check("done", 128'(done), 128'(exp_done));
            if (exp_valid) check("data", bus.m_cfg_data, exp_word(b, s, l, issued));
            if (exp_done) begin
                check("cycle_cnt_done", 128'(cycle_cnt), 128'(run_cycles));
                check("err_ack_run", 128'(err_ack), 128'(0));
                seen_done = 1;
            end else begin
                run_cycles++;
            end
            if (exp_valid && bus.m_cfg_ready) issued++;
            if (bus.ack) acked++;
        end
        if (!seen_done) check("timeout", 128'(0), 128'(1));
        @(negedge clk);
        start = 1'b0;
        bus.ack = 1'b0;
        bus.m_cfg_ready = 1'b0;
        #1;
        check("busy_after", 128'(busy), 128'(0));
        check("done_after", 128'(done), 128'(0));
        check("cycle_cnt_hold", 128'(cycle_cnt), 128'(run_cycles));
    endtask

    initial begin
        bus.m_cfg_ready = 1'b0;
        bus.ack = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_valid", 128'(bus.m_cfg_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_data", bus.m_cfg_data, 128'(0));
        check("rst_cycle_cnt", 128'(cycle_cnt), 128'(0));
        check("rst_err_ack", 128'(err_ack), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        run_cfg(32'h0000_1000, 32'h40, 16'd3, 16'd8, 100, 100, 1);
        run_cfg(32'h0000_2000, 32'h10, 16'd6, 16'd4, 100, 60, 12);
        run_cfg(32'h0000_3000, 32'h20, 16'd5, 16'd2, 30, 50, 0);
        run_cfg(32'hFFFF_FFC0, 32'h40, 16'd2, 16'd1, 100, 80, 0);
        run_cfg(32'h1234_5678, 32'h8, 16'd0, 16'd3, 100, 100, 0);
        for (int r = 0; r < 8; r++) begin
            run_cfg($urandom, $urandom, 16'($urandom_range(1, 12)), 16'($urandom),
                    $urandom_range(40, 100), $urandom_range(30, 90), $urandom_range(0, 5));
        end

        // Abort mid-run, then a late ack must flag an error.
        @(negedge clk);
        base_addr = 32'h0000_8000;
        stride    = 32'h100;
        n_cfg     = 16'd6;
        cfg_len   = 16'd16;
        start     = 1'b1;
        bus.m_cfg_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("abort_valid", 128'(bus.m_cfg_valid), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_data", bus.m_cfg_data, 128'(0));
        check("abort_cycle_cnt", 128'(cycle_cnt), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        bus.m_cfg_ready = 1'b0;
        @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        #1;
        check("late_ack_err", 128'(err_ack), 128'(1));
        check("late_ack_busy", 128'(busy), 128'(0));
        run_cfg(32'h0000_9000, 32'h40, 16'd4, 16'd7, 70, 70, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
